toggle_bank: RTL

TOGGLE_BANK -- requirements
Module: toggle_bank

---
 rtl/toggle_bank.sv | 115 +++++++++++
 1 files changed

// File: rtl/toggle_bank.sv
// toggle_bank: a bank of independent toggle channels (LED-style).
// Each channel synchronizes an asynchronous request, debounces it, and
// inverts its output on a qualified event. MODE 1 qualifies on a debounced
// rising edge; MODE 0 qualifies on every cycle the debounced level is high.

module toggle_lane #(
    parameter int MODE            = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic en,
    input  logic clr,
    output logic q,
    output logic tog
);
    localparam int              CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;
    logic                   db;
    logic                   rise;
    logic                   qual;
    logic                   flip;

    assign s = sync[SYNC_STAGES-1];

    // Input synchronizer chain; stage 0 takes the raw asynchronous request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= '0;
        else      sync <= {sync[SYNC_STAGES-2:0], d};
    end

    // Debounce: db follows s only after DEBOUNCE_CYCLES consecutive
    // disagreeing cycles; any agreement restarts the count from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (s == db) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            db  <= s;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // The edge at which db is about to go 0->1.
    assign rise = s && !db && (cnt == CNT_MAX);

    generate
        if (MODE == 1) begin : g_edge
            assign qual = rise;
        end else begin : g_level
            assign qual = db;
        end
    endgenerate

    // A suppressed (en low) or cleared event is dropped, never remembered.
    assign flip = qual && en && !clr;

    // Output state and one-cycle change marker; clr wins over everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q   <= 1'b0;
            tog <= 1'b0;
        end else if (clr) begin
            q   <= 1'b0;
            tog <= 1'b0;
        end else begin
            q   <= q ^ flip;
            tog <= flip;
        end
    end
endmodule

module toggle_bank #(
    parameter int CHANNELS        = 5,
    parameter int MODE            = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] d,
    input  logic                en,
    input  logic                clr,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] tog
);
    // One fully independent lane per channel; en/clr are shared.
    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
            toggle_lane #(
                .MODE            (MODE),
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_lane (
                .clk (clk),
                .rst (rst),
                .d   (d[i]),
                .en  (en),
                .clr (clr),
                .q   (q[i]),
                .tog (tog[i])
            );
        end
    endgenerate
endmodule
